// File: rtl/uart_tx_scheduler_if.sv
// Bundle between the requesting blocks, the UART transmitter and uart_tx_scheduler.
// master is the scheduler side; slave is the requester/UART side.
interface uart_tx_scheduler_if #(
    parameter int NREQ    = 4,
    parameter int D_WIDTH = 13
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]              req;
    logic [NREQ-1:0][D_WIDTH-1:0] req_data;
    logic [NREQ-1:0]              ack;
    logic                         tx_ena;
    logic [D_WIDTH-1:0]           tx_data;
    logic                         tx_busy;
    logic [IDW-1:0]               grant_id;
    logic                         sched_busy;
    logic                         err_tmo;

    modport master (
        input  req, req_data, tx_busy,
        output ack, tx_ena, tx_data, grant_id, sched_busy, err_tmo
    );

    modport slave (
        output req, req_data, tx_busy,
        input  ack, tx_ena, tx_data, grant_id, sched_busy, err_tmo
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters.
// One word per frame; next grant only after tx_busy falls plus GAP_CYCLES idle cycles.
module uart_tx_scheduler #(
    parameter int NREQ       = 4,
    parameter int D_WIDTH    = 13,
    parameter int GAP_CYCLES = 2,
    parameter int BUSY_TMO   = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_scheduler_if.master bus
);
    localparam int IDW  = $clog2(NREQ);
    localparam int IDW1 = IDW + 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LAUNCH    = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    localparam logic [3:0]     GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);
    localparam logic [3:0]     TMO_LAST = 4'(BUSY_TMO - 1);
    localparam logic [IDW1-1:0] NREQ_W  = IDW1'(NREQ);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ - 1);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("uart_tx_scheduler: NREQ must be 2..8");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_bad_gap
        $error("uart_tx_scheduler: GAP_CYCLES must be 0..15");
    end
    if (BUSY_TMO < 1 || BUSY_TMO > 15) begin : g_bad_tmo
        $error("uart_tx_scheduler: BUSY_TMO must be 1..15");
    end

    logic [2:0]         state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [3:0]         tmo_cnt, tmo_cnt_nxt;
    logic [3:0]         gap_cnt, gap_cnt_nxt;
    logic [NREQ-1:0]    ack_nxt;
    logic               tx_ena_nxt;
    logic               err_tmo_nxt;
    logic [D_WIDTH-1:0] tx_data_nxt;
    logic [IDW-1:0]     grant_id_nxt;

    logic [NREQ-1:0][IDW-1:0] cand_idx;
    logic [NREQ-1:0]          cand_req;
    logic [IDW-1:0]           win;
    logic                     win_vld;

    // Offset g looks at requester (ptr+g) mod NREQ; ptr < NREQ so one subtract suffices.
    for (genvar g = 0; g < NREQ; g++) begin : g_rot
        logic [IDW1-1:0] sum;
        assign sum         = {1'b0, ptr} + IDW1'(g);
        assign cand_idx[g] = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
        assign cand_req[g] = bus.req[cand_idx[g]];
    end

    // Lowest offset wins, so the scan runs downward and the last hit sticks.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand_req[i]) begin
                win     = cand_idx[i];
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        tmo_cnt_nxt  = tmo_cnt;
        gap_cnt_nxt  = gap_cnt;
        ack_nxt      = '0;
        tx_ena_nxt   = 1'b0;
        err_tmo_nxt  = 1'b0;
        tx_data_nxt  = bus.tx_data;
        grant_id_nxt = bus.grant_id;

        case (state)
            S_IDLE: begin
                if (win_vld) begin
                    tx_data_nxt   = bus.req_data[win];
                    tx_ena_nxt    = 1'b1;
                    ack_nxt[win]  = 1'b1;
                    grant_id_nxt  = win;
                    ptr_nxt       = (win == LAST_ID) ? '0 : win + IDW'(1);
                    state_nxt     = S_LAUNCH;
                end
            end
            // req is deliberately ignored here: the winner may still hold req this cycle.
            S_LAUNCH: begin
                tmo_cnt_nxt = '0;
                state_nxt   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_nxt = S_WAIT_DONE;
                end else if (tmo_cnt == TMO_LAST) begin
                    err_tmo_nxt = 1'b1;
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 4'd1;
                end
            end
            S_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    gap_cnt_nxt = GAP_LOAD;
                    state_nxt   = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == 4'd0) state_nxt = S_IDLE;
                else                 gap_cnt_nxt = gap_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // sched_busy is registered from the next state so it lines up with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_IDLE;
            ptr            <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            bus.ack        <= '0;
            bus.tx_ena     <= 1'b0;
            bus.tx_data    <= '0;
            bus.grant_id   <= '0;
            bus.sched_busy <= 1'b0;
            bus.err_tmo    <= 1'b0;
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            tmo_cnt        <= tmo_cnt_nxt;
            gap_cnt        <= gap_cnt_nxt;
            bus.ack        <= ack_nxt;
            bus.tx_ena     <= tx_ena_nxt;
            bus.tx_data    <= tx_data_nxt;
            bus.grant_id   <= grant_id_nxt;
            bus.sched_busy <= (state_nxt != S_IDLE);
            bus.err_tmo    <= err_tmo_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: NREQ=4/GAP=2 instance plus NREQ=3/GAP=0 instance,
// each driven against a simple UART model whose frame lasts FRAME cycles.
module tb_uart_tx_scheduler;
    localparam int FRAME = 5;

    logic clk;
    logic rst;
    logic ua_en, ub_en;
    int   ua_cnt, ub_cnt;
    int   checks = 0;
    int   errors = 0;

    uart_tx_scheduler_if #(.NREQ(4), .D_WIDTH(13)) ia ();
    uart_tx_scheduler_if #(.NREQ(3), .D_WIDTH(13)) ib ();

    uart_tx_scheduler #(.NREQ(4), .D_WIDTH(13), .GAP_CYCLES(2), .BUSY_TMO(4)) dut_a (
        .clk(clk), .rst(rst), .bus(ia)
    );
    uart_tx_scheduler #(.NREQ(3), .D_WIDTH(13), .GAP_CYCLES(0), .BUSY_TMO(4)) dut_b (
        .clk(clk), .rst(rst), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy rises the edge after tx_ena and stays high FRAME cycles.
    always @(posedge clk) begin
        if (!rst) begin
            ia.tx_busy <= 1'b0; ua_cnt <= 0;
        end else if (ua_en && ia.tx_ena) begin
            ia.tx_busy <= 1'b1; ua_cnt <= FRAME - 1;
        end else if (ua_cnt != 0) begin
            ua_cnt <= ua_cnt - 1;
        end else begin
            ia.tx_busy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            ib.tx_busy <= 1'b0; ub_cnt <= 0;
        end else if (ub_en && ib.tx_ena) begin
            ib.tx_busy <= 1'b1; ub_cnt <= FRAME - 1;
        end else if (ub_cnt != 0) begin
            ub_cnt <= ub_cnt - 1;
        end else begin
            ib.tx_busy <= 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One grant on instance A. Non-first steps start one cycle after the previous
    // grant: 8 more cycles reach the IDLE cycle, the 10th cycle carries tx_ena.
    task automatic grant_step(input int id, input bit first, input bit rerq);
        if (!first) begin
            tick(8);
            chk("gap_no_ena", 32'(ia.tx_ena), 32'd0);
            chk("gap_idle", 32'(ia.sched_busy), 32'd0);
        end
        tick(1);
        chk("grant_ena", 32'(ia.tx_ena), 32'd1);
        chk("grant_id", 32'(ia.grant_id), 32'(id));
        chk("grant_ack", 32'(ia.ack), 32'd1 << id);
        chk("grant_data", 32'(ia.tx_data), 32'h100 + 32'(id));
        ia.req[id] = 1'b0;
        tick(1);
        chk("ena_pulse", 32'(ia.tx_ena), 32'd0);
        chk("ack_pulse", 32'(ia.ack), 32'd0);
        if (rerq) ia.req[id] = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        ua_en = 1'b1;
        ub_en = 1'b1;
        ia.req = '0;
        ib.req = '0;
        for (int i = 0; i < 4; i++) ia.req_data[i] = 13'(32'h100 + i);
        for (int i = 0; i < 3; i++) ib.req_data[i] = 13'(32'h1A0 + i);

        // reset state
        tick(3);
        chk("rst_ack", 32'(ia.ack), 32'd0);
        chk("rst_ena", 32'(ia.tx_ena), 32'd0);
        chk("rst_data", 32'(ia.tx_data), 32'd0);
        chk("rst_gid", 32'(ia.grant_id), 32'd0);
        chk("rst_err", 32'(ia.err_tmo), 32'd0);
        chk("rst_busy", 32'(ia.sched_busy), 32'd0);
        chk("rst_b_busy", 32'(ib.sched_busy), 32'd0);
        rst = 1'b1;

        // single requester 2; grant at L, busy L+1..L+5, GAP L+7..L+8, IDLE L+9
        tick(1);
        ia.req_data[2] = 13'h0A5;
        ia.req[2] = 1'b1;
        tick(1);
        chk("t1_ena", 32'(ia.tx_ena), 32'd1);
        chk("t1_data", 32'(ia.tx_data), 32'h0A5);
        chk("t1_ack", 32'(ia.ack), 32'b0100);
        chk("t1_gid", 32'(ia.grant_id), 32'd2);
        chk("t1_sbusy", 32'(ia.sched_busy), 32'd1);
        ia.req[2] = 1'b0;
        ia.req_data[2] = 13'h102;
        tick(1);
        chk("t1_ena_pulse", 32'(ia.tx_ena), 32'd0);
        chk("t1_ack_pulse", 32'(ia.ack), 32'd0);
        tick(5);
        chk("t1_uart_done", 32'(ia.tx_busy), 32'd0);
        chk("t1_wait_done", 32'(ia.sched_busy), 32'd1);
        tick(2);
        chk("t1_gap_last", 32'(ia.sched_busy), 32'd1);
        tick(1);
        chk("t1_idle", 32'(ia.sched_busy), 32'd0);

        // reset again so ptr starts at 0; all four requesters pending
        rst = 1'b0;
        tick(1);
        chk("t2_rst_gid", 32'(ia.grant_id), 32'd0);
        rst = 1'b1;
        ia.req = 4'b1111;
        grant_step(0, 1'b1, 1'b0);
        grant_step(1, 1'b0, 1'b0);
        grant_step(2, 1'b0, 1'b0);
        grant_step(3, 1'b0, 1'b0);

        // req 1 keeps re-asserting, req 3 pending; ptr wraps 3->0 first
        ia.req = 4'b1010;
        grant_step(1, 1'b0, 1'b1);
        grant_step(3, 1'b0, 1'b1);
        grant_step(1, 1'b0, 1'b1);
        grant_step(3, 1'b0, 1'b0);
        ia.req = '0;
        tick(8);
        chk("t3_idle", 32'(ia.sched_busy), 32'd0);

        // UART silent: WAIT_BUSY L+1..L+4, err_tmo in L+5, GAP, regrant at L+8
        ua_en = 1'b0;
        ia.req = 4'b0011;
        grant_step(0, 1'b1, 1'b0);
        tick(3);
        chk("t4_no_err_yet", 32'(ia.err_tmo), 32'd0);
        tick(1);
        chk("t4_err", 32'(ia.err_tmo), 32'd1);
        tick(1);
        chk("t4_err_pulse", 32'(ia.err_tmo), 32'd0);
        chk("t4_in_gap", 32'(ia.sched_busy), 32'd1);
        tick(1);
        chk("t4_idle", 32'(ia.sched_busy), 32'd0);
        tick(1);
        ua_en = 1'b1;
        chk("t4_regrant_ena", 32'(ia.tx_ena), 32'd1);
        chk("t4_regrant_id", 32'(ia.grant_id), 32'd1);

        // reset in WAIT_DONE with 0 and 3 pending; ptr would be 2 without reset
        ia.req = 4'b1001;
        tick(3);
        chk("t5_pre_busy", 32'(ia.sched_busy), 32'd1);
        chk("t5_pre_gid", 32'(ia.grant_id), 32'd1);
        rst = 1'b0;
        tick(1);
        chk("t5_ack", 32'(ia.ack), 32'd0);
        chk("t5_ena", 32'(ia.tx_ena), 32'd0);
        chk("t5_data", 32'(ia.tx_data), 32'd0);
        chk("t5_gid", 32'(ia.grant_id), 32'd0);
        chk("t5_err", 32'(ia.err_tmo), 32'd0);
        chk("t5_sbusy", 32'(ia.sched_busy), 32'd0);
        rst = 1'b1;
        grant_step(0, 1'b1, 1'b0);
        grant_step(3, 1'b0, 1'b0);
        tick(8);
        chk("t5_idle", 32'(ia.sched_busy), 32'd0);

        // NREQ=3, no gap: grant at L, WAIT_DONE sees busy low at L+6, IDLE at L+7
        ib.req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            chk("t6_ena", 32'(ib.tx_ena), 32'd1);
            chk("t6_gid", 32'(ib.grant_id), 32'(k % 3));
            chk("t6_ack", 32'(ib.ack), 32'd1 << (k % 3));
            chk("t6_data", 32'(ib.tx_data), 32'h1A0 + 32'(k % 3));
            tick(6);
            chk("t6_wait_done", 32'(ib.sched_busy), 32'd1);
            tick(1);
            chk("t6_idle", 32'(ib.sched_busy), 32'd0);
            if (k == 3) ib.req = '0;
        end
        tick(2);
        chk("t6_quiet", 32'(ib.sched_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
